anim_sprite_engine: RTL and testbench

Parametrised, pipelined sprite renderer: the generalised successor of the per-pose character sprite blocks. One instance draws any fighter pose sheet: integer power-of-two scaling, horizontal mirroring for the player facing left, multi-frame animation stepped by a vblank-synchronous FSM, and tear-free position latching. It sits between the sprite ROM/palette pair and the VGA colour mux. It emits `sprite_on` plus 4-bit RGB, pipeline-aligned to a registered DrawX/DrawY stream.

---
 rtl/anim_sprite_engine.sv | 136 +++++++++++++
 tb/tb_anim_sprite_engine.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/anim_sprite_engine.sv
// anim_sprite_engine: scaled, mirrorable, animated sprite renderer with a 3-stage pixel pipeline
module anim_sprite_engine #(
    parameter int SPR_W = 92,
    parameter int SPR_H = 90,
    parameter int SCALE_SH = 1,
    parameter int FRAMES = 4,
    parameter int HOLD = 6,
    parameter int ADDR_W = 16,
    parameter logic [3:0] KEY_R = 4'hF,
    parameter logic [3:0] KEY_G = 4'h0,
    parameter logic [3:0] KEY_B = 4'hF,
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1
) (
    input  logic              vga_clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic [9:0]        SprX,
    input  logic [9:0]        SprY,
    input  logic              flip,
    input  logic              start,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    input  logic [3:0]        pal_r,
    input  logic [3:0]        pal_g,
    input  logic [3:0]        pal_b,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              sprite_on,
    output logic [FW-1:0]     frame_idx,
    output logic              anim_done
);
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    localparam int FRAME_SZ = SPR_W * SPR_H;
    state_t state_q;
    logic [FW-1:0] frame_idx_q;
    logic [HW-1:0] hc_q;
    logic done_q;
    logic [9:0] xl_q, yl_q;
    logic fl_q;
    logic [10:0] dx, dy;
    logic [9:0] u0, u, v;
    logic hit_d, opaque_d;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic hit_q, blank_q, hit_q2, blank_q2;
    logic [3:0] red_q, green_q, blue_q;
    logic on_q;
    logic unused_rom_q;
    // Colour comes from the combinational palette, so the raw index is not needed here
    assign unused_rom_q = ^rom_q;
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q <= IDLE;
            frame_idx_q <= '0;
            hc_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                state_q <= PLAY;
                frame_idx_q <= '0;
                hc_q <= '0;
            end else if (state_q == PLAY && frame_start) begin
                if (hc_q < HW'(HOLD - 1)) begin
                    hc_q <= hc_q + 1'b1;
                end else begin
                    hc_q <= '0;
                    if (frame_idx_q < FW'(FRAMES - 1)) begin
                        frame_idx_q <= frame_idx_q + 1'b1;
                    end else if (loop) begin
                        frame_idx_q <= '0;
                    end else begin
                        state_q <= DONE;
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            xl_q <= '0;
            yl_q <= '0;
            fl_q <= 1'b0;
        end else if (frame_start) begin
            xl_q <= SprX;
            yl_q <= SprY;
            fl_q <= flip;
        end
    end
    always_comb begin
        dx = {1'b0, DrawX} - {1'b0, xl_q};
        dy = {1'b0, DrawY} - {1'b0, yl_q};
        hit_d = !dx[10] && dx < 11'(SPR_W << SCALE_SH) && !dy[10] && dy < 11'(SPR_H << SCALE_SH);
        u0 = dx[9:0] >> SCALE_SH;
        u = fl_q ? 10'(SPR_W - 1) - u0 : u0;
        v = dy[9:0] >> SCALE_SH;
        addr_d = hit_d ? ADDR_W'(32'(frame_idx_q) * FRAME_SZ + 32'(v) * SPR_W + 32'(u)) : '0;
        opaque_d = hit_q2 && blank_q2 && {pal_r, pal_g, pal_b} != {KEY_R, KEY_G, KEY_B};
    end
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            addr_q <= '0;
            hit_q <= 1'b0;
            blank_q <= 1'b0;
            hit_q2 <= 1'b0;
            blank_q2 <= 1'b0;
            red_q <= '0;
            green_q <= '0;
            blue_q <= '0;
            on_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            hit_q <= hit_d;
            blank_q <= blank;
            hit_q2 <= hit_q;
            blank_q2 <= blank_q;
            red_q <= opaque_d ? pal_r : 4'h0;
            green_q <= opaque_d ? pal_g : 4'h0;
            blue_q <= opaque_d ? pal_b : 4'h0;
            on_q <= opaque_d;
        end
    end
    assign rom_addr = addr_q;
    assign red = red_q;
    assign green = green_q;
    assign blue = blue_q;
    assign sprite_on = on_q;
    assign frame_idx = frame_idx_q;
    assign anim_done = done_q;
endmodule

// File: tb/tb_anim_sprite_engine.sv
// tb_anim_sprite_engine: scoreboard bench with a ROM/palette model around anim_sprite_engine
module tb_anim_sprite_engine;
    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;
    logic Reset, blank, frame_start, flip, start, loop;
    logic [9:0] DrawX, DrawY, SprX, SprY;
    logic [15:0] rom_addr;
    logic [3:0] rom_q = 4'h0;
    logic [3:0] pal_r, pal_g, pal_b, red, green, blue;
    logic sprite_on, anim_done;
    logic [1:0] frame_idx;
    int total = 0, passed = 0;
    int aq[$];
    logic [12:0] pq[$];
    logic v_in = 1'b0;
    logic [2:0] vs = 3'b0;
    int fi, dn;

    anim_sprite_engine dut (
        .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_start(frame_start), .SprX(SprX), .SprY(SprY), .flip(flip), .start(start),
        .loop(loop), .rom_addr(rom_addr), .rom_q(rom_q), .pal_r(pal_r), .pal_g(pal_g),
        .pal_b(pal_b), .red(red), .green(green), .blue(blue), .sprite_on(sprite_on),
        .frame_idx(frame_idx), .anim_done(anim_done)
    );

    // ROM holds the low nibble of its address; index 5 is the colour key, 9 is 8/4/2
    function automatic logic [11:0] pal(input logic [3:0] i);
        return (i == 4'd5) ? 12'hF0F : (i == 4'd9) ? 12'h842 : {i, i, i};
    endfunction
    assign {pal_r, pal_g, pal_b} = pal(rom_q);
    always @(posedge vga_clk) rom_q <= rom_addr[3:0];

    function automatic void chk(input string n, input int a, input int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d", n, a, e);
    endfunction

    task automatic pix(input int x, input int y, input logic bl, input logic hit, input int addr);
        logic [11:0] c;
        logic on;
        @(negedge vga_clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = bl;
        v_in = 1'b1;
        c = pal(4'(addr));
        on = hit && bl && c != 12'hF0F;
        aq.push_back(addr);
        pq.push_back(on ? {1'b1, c} : 13'd0);
    endtask

    task automatic vblank(output int f, output int d);
        @(negedge vga_clk);
        v_in = 1'b0;
        frame_start = 1'b1;
        @(posedge vga_clk);
        #1;
        f = int'(frame_idx);
        d = int'(anim_done);
        @(negedge vga_clk);
        frame_start = 1'b0;
        @(posedge vga_clk);
        #1;
        chk("done_one_cycle", int'(anim_done), 0);
    endtask

    task automatic pulse_start();
        @(negedge vga_clk);
        v_in = 1'b0;
        start = 1'b1;
        @(negedge vga_clk);
        start = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge vga_clk);
            vs = {vs[1:0], v_in};
            #1;
            if (vs[0]) begin
                if (aq.size() == 0) chk("addr_queue_underrun", 1, 0);
                else chk("rom_addr", int'(rom_addr), aq.pop_front());
            end
            if (vs[2]) begin
                if (pq.size() == 0) chk("pixel_queue_underrun", 1, 0);
                else chk("pixel_on_rgb", int'({sprite_on, red, green, blue}), int'(pq.pop_front()));
            end
        end
    end

    initial begin
        Reset = 1'b1; blank = 1'b0; frame_start = 1'b0; flip = 1'b0; start = 1'b0; loop = 1'b0;
        DrawX = '0; DrawY = '0; SprX = '0; SprY = '0;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_rgb_on", int'({sprite_on, red, green, blue}), 0);
        chk("reset_frame_idx", int'(frame_idx), 0);
        chk("reset_anim_done", int'(anim_done), 0);
        @(negedge vga_clk);
        Reset = 1'b0;
        SprX = 10'd100; SprY = 10'd50;
        vblank(fi, dn);
        chk("idle_frame_idx", fi, 0);
        for (int x = 98; x <= 300; x++) begin
            pix(x, 50, 1'b1, x >= 100 && x <= 283, (x >= 100 && x <= 283) ? (x - 100) >> 1 : 0);
        end
        pix(100, 52, 1'b1, 1'b1, 92);
        pix(183, 229, 1'b1, 1'b1, 8229);
        pix(100, 230, 1'b1, 1'b0, 0);
        pix(99, 60, 1'b1, 1'b0, 0);
        flip = 1'b1;
        vblank(fi, dn);
        pix(100, 50, 1'b1, 1'b1, 91);
        pix(283, 50, 1'b1, 1'b1, 0);
        pix(102, 50, 1'b1, 1'b1, 90);
        flip = 1'b0;
        vblank(fi, dn);
        pix(110, 50, 1'b1, 1'b1, 5);
        pix(118, 50, 1'b1, 1'b1, 9);
        pix(118, 50, 1'b0, 1'b1, 9);
        SprX = 10'd200;
        pix(110, 50, 1'b1, 1'b1, 5);
        pix(210, 50, 1'b1, 1'b1, 55);
        vblank(fi, dn);
        pix(110, 50, 1'b1, 1'b0, 0);
        pix(210, 50, 1'b1, 1'b1, 5);
        SprX = 10'd100;
        loop = 1'b0;
        pulse_start();
        for (int p = 1; p <= 24; p++) begin
            vblank(fi, dn);
            chk($sformatf("noloop_frame_p%0d", p), fi, (p >= 18) ? 3 : p / 6);
            chk($sformatf("noloop_done_p%0d", p), dn, (p == 24) ? 1 : 0);
            if (p == 12) pix(100, 50, 1'b1, 1'b1, 16560);
        end
        for (int p = 0; p < 3; p++) begin
            vblank(fi, dn);
            chk("done_hold_frame", fi, 3);
            chk("done_no_repulse", dn, 0);
        end
        loop = 1'b1;
        pulse_start();
        for (int p = 1; p <= 24; p++) begin
            vblank(fi, dn);
            chk($sformatf("loop_frame_p%0d", p), fi, (p / 6) % 4);
            chk($sformatf("loop_done_p%0d", p), dn, 0);
        end
        for (int p = 0; p < 7; p++) vblank(fi, dn);
        chk("pre_restart_frame", fi, 1);
        @(negedge vga_clk);
        start = 1'b1;
        frame_start = 1'b1;
        @(posedge vga_clk);
        #1;
        chk("restart_coincident_frame", int'(frame_idx), 0);
        @(negedge vga_clk);
        start = 1'b0;
        frame_start = 1'b0;
        for (int p = 1; p <= 6; p++) begin
            vblank(fi, dn);
            chk($sformatf("restart_hc_p%0d", p), fi, p / 6);
        end
        @(negedge vga_clk);
        DrawX = 10'd150; DrawY = 10'd60; blank = 1'b1;
        repeat (4) @(posedge vga_clk);
        #1;
        chk("pre_reset_sprite_on", int'(sprite_on), 1);
        chk("pre_reset_rom_addr", int'(rom_addr), 8765);
        @(negedge vga_clk);
        Reset = 1'b1;
        @(posedge vga_clk);
        #1;
        chk("midreset_rom_addr", int'(rom_addr), 0);
        chk("midreset_rgb_on", int'({sprite_on, red, green, blue}), 0);
        chk("midreset_frame_idx", int'(frame_idx), 0);
        chk("midreset_anim_done", int'(anim_done), 0);
        @(negedge vga_clk);
        Reset = 1'b0;
        for (int p = 1; p <= 6; p++) begin
            vblank(fi, dn);
            chk("post_reset_idle", fi, 0);
        end
        repeat (4) @(negedge vga_clk);
        chk("addr_queue_drained", aq.size(), 0);
        chk("pixel_queue_drained", pq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
